// File: rtl/fft_agu_pkg.sv
// fft_agu_pkg: FSM states and address helpers for fft_addr_gen_param.
// FFT_AGU_BITREV_EN adds the UNLOAD state.
package fft_agu_pkg;
  localparam int MAX_W = 12;
  typedef enum logic [1:0] {
    IDLE,
    RUN,
`ifdef FFT_AGU_BITREV_EN
    DRAIN,
    UNLOAD
`else
    DRAIN
`endif
  } agu_state_t;
  function automatic logic [MAX_W-1:0] rotl_n(input logic [MAX_W-1:0] value, input int amount, input int width);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_W; i++)
      if (i < width) r = r | (((value >> i) & MAX_W'(1)) << ((i + amount) % width));
    return r;
  endfunction
  function automatic logic [MAX_W-1:0] bitrev_n(input logic [MAX_W-1:0] value, input int width);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_W; i++)
      if (i < width) r = r | (((value >> i) & MAX_W'(1)) << (width - 1 - i));
    return r;
  endfunction
  // Top s bits of a width-bit twiddle index: stage 0 shares one twiddle, the last stage uses all.
  function automatic logic [MAX_W-1:0] tw_mask(input int s, input int width);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_W; i++)
      if (i < width && i >= width - s) r = r | (MAX_W'(1) << i);
    return r;
  endfunction
endpackage

// File: rtl/fft_agu_wr_delay.sv
// fft_agu_wr_delay: fixed-latency shift-register delay line with async active-low clear.
module fft_agu_wr_delay #(
  parameter int W   = 8,
  parameter int LAT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] sr [LAT];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) sr[i] <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < LAT; i++) sr[i] <= sr[i-1];
    end
  end
  assign q = sr[LAT-1];
endmodule

// File: rtl/fft_addr_gen_param.sv
// fft_addr_gen_param: constant-geometry radix-2 FFT read/twiddle/write address sequencer.
// Define FFT_AGU_BITREV_EN to append a bit-reversed unload pass before done.
module fft_addr_gen_param
  import fft_agu_pkg::*;
#(
  parameter int LOG2N  = 5,
  parameter int WR_LAT = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(LOG2N)-1:0] stage,
  output logic                     rd_valid,
  output logic [LOG2N-1:0]         rd_addr_a,
  output logic [LOG2N-1:0]         rd_addr_b,
  output logic [LOG2N-2:0]         tw_addr,
  output logic                     wr_en,
  output logic [LOG2N-1:0]         wr_addr_a,
  output logic [LOG2N-1:0]         wr_addr_b,
  output logic                     out_valid,
  output logic [LOG2N-1:0]         out_addr
);
  localparam int STG_W = $clog2(LOG2N);
  localparam int TW_W  = LOG2N - 1;
  localparam int HALF  = 2 ** (LOG2N - 1);
  localparam int DW    = 2 * LOG2N + 1;
  agu_state_t       state, nstate;
  logic [LOG2N-1:0] cnt, ncnt;
  logic [3:0]       dcnt, ndcnt;
  logic [STG_W-1:0] stg, nstg;
  logic             done_q, ndone;
  logic [TW_W-1:0]  j;
  logic [DW-1:0]    wq;
  assign j = cnt[TW_W-1:0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      dcnt   <= '0;
      stg    <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= nstate;
      cnt    <= ncnt;
      dcnt   <= ndcnt;
      stg    <= nstg;
      done_q <= ndone;
    end
  end
  always_comb begin
    nstate = state;
    ncnt   = cnt;
    ndcnt  = dcnt;
    nstg   = stg;
    ndone  = 1'b0;
    case (state)
      IDLE: begin
        nstate = start ? RUN : IDLE;
        ncnt   = '0;
        nstg   = '0;
      end
      RUN: begin
        ncnt = (cnt == LOG2N'(HALF - 1)) ? '0 : cnt + LOG2N'(1);
        nstate = (cnt == LOG2N'(HALF - 1)) ? DRAIN : RUN;
        ndcnt = '0;
      end
      DRAIN: begin
        ndcnt = dcnt + 4'd1;
        // Hold off the next stage until the last write of this stage has landed.
        if (dcnt == 4'(WR_LAT - 1)) begin
          if (stg == STG_W'(LOG2N - 1)) begin
`ifdef FFT_AGU_BITREV_EN
            nstate = UNLOAD;
            ncnt   = '0;
`else
            nstate = IDLE;
            ndone  = 1'b1;
            nstg   = '0;
`endif
          end else begin
            nstate = RUN;
            nstg   = stg + STG_W'(1);
          end
        end
      end
`ifdef FFT_AGU_BITREV_EN
      UNLOAD: begin
        ncnt   = cnt + LOG2N'(1);
        nstate = (cnt == '1) ? IDLE : UNLOAD;
        ndone  = (cnt == '1);
        nstg   = (cnt == '1) ? '0 : stg;
      end
`endif
      default: nstate = IDLE;
    endcase
  end
  assign busy      = (state != IDLE);
  assign done      = done_q;
  assign stage     = stg;
  assign rd_valid  = (state == RUN);
  assign rd_addr_a = rd_valid ? LOG2N'(rotl_n(MAX_W'({j, 1'b0}), int'(stg), LOG2N)) : '0;
  assign rd_addr_b = rd_valid ? LOG2N'(rotl_n(MAX_W'({j, 1'b1}), int'(stg), LOG2N)) : '0;
  assign tw_addr   = rd_valid ? (TW_W'(tw_mask(int'(stg), TW_W)) & j) : '0;
`ifdef FFT_AGU_BITREV_EN
  assign out_valid = (state == UNLOAD);
  assign out_addr  = out_valid ? LOG2N'(bitrev_n(MAX_W'(cnt), LOG2N)) : '0;
`else
  assign out_valid = 1'b0;
  assign out_addr  = '0;
`endif
  fft_agu_wr_delay #(.W(DW), .LAT(WR_LAT)) u_wr_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({rd_valid, rd_addr_a, rd_addr_b}),
    .q     (wq)
  );
  assign {wr_en, wr_addr_a, wr_addr_b} = wq;
endmodule

// File: tb/tb_fft_addr_gen_param.sv
// tb_fft_addr_gen_param: cycle-count reference model plus directed vector table for fft_addr_gen_param.
module tb_fft_addr_gen_param;
`ifdef FFT_AGU_BITREV_EN
  localparam int LOG2N = 3;
  localparam int WR_LAT = 1;
`else
  localparam int LOG2N = 5;
  localparam int WR_LAT = 4;
`endif
  localparam int STG_W = $clog2(LOG2N);
  localparam int NPTS = 2 ** LOG2N;
  localparam int HALF = NPTS / 2;
  localparam int P = HALF + WR_LAT;
`ifdef FFT_AGU_BITREV_EN
  localparam int DONE_C = 1 + LOG2N * P + NPTS;
`else
  localparam int DONE_C = 1 + LOG2N * P;
`endif
  localparam int ABORT_C = (DONE_C > 46) ? 40 : DONE_C / 2;

  typedef struct packed {
    logic busy; logic done; logic [STG_W-1:0] stg; logic rv;
    logic [LOG2N-1:0] a; logic [LOG2N-1:0] b; logic [LOG2N-2:0] tw;
    logic we; logic [LOG2N-1:0] wa; logic [LOG2N-1:0] wb;
    logic ov; logic [LOG2N-1:0] oa;
  } obs_t;
  typedef enum {S_A, S_B, S_TW, S_RV, S_WE, S_WA, S_WB, S_BUSY, S_DONE, S_STG, S_OV, S_OA} sig_e;
  typedef struct {string name; int cyc; sig_e sig; int val;} vec_t;

  logic clk = 0, rst_n = 1, start = 0;
  logic busy, done, rd_valid, wr_en, out_valid;
  logic [STG_W-1:0] stage;
  logic [LOG2N-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b, out_addr;
  logic [LOG2N-2:0] tw_addr;
  int checks = 0, failures = 0, mc = 0, done_cnt = 0;
  bit chk_en = 0, rec_en = 0;
  obs_t trace [DONE_C+1];
  vec_t vecs[$];

  fft_addr_gen_param #(.LOG2N(LOG2N), .WR_LAT(WR_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .stage(stage),
    .rd_valid(rd_valid), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_addr(tw_addr),
    .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
    .out_valid(out_valid), .out_addr(out_addr)
  );

  always #5 clk = ~clk;

  function automatic int rotl(int v, int s);
    return ((v << s) | (v >> (LOG2N - s))) & (NPTS - 1);
  endfunction
  function automatic int twm(int s);
    return ((1 << s) - 1) << (LOG2N - 1 - s);
  endfunction
  function automatic int brev(int v);
    int r;
    r = 0;
    for (int i = 0; i < LOG2N; i++) r = (r << 1) | ((v >> i) & 1);
    return r;
  endfunction
  // Reads of stage s fill the first N/2 cycles of each P-cycle slot starting at cycle 1.
  function automatic bit read_at(int c, output int a, output int b, output int tw);
    int s, j;
    a = 0; b = 0; tw = 0;
    if (c < 1) return 0;
    s = (c - 1) / P;
    j = (c - 1) % P;
    if (s >= LOG2N || j >= HALF) return 0;
    a = rotl(2 * j, s);
    b = rotl(2 * j + 1, s);
    tw = j & twm(s);
    return 1;
  endfunction
  function automatic obs_t expect_at(int c);
    obs_t e;
    int a, b, tw, s;
    e = '0;
    if (c > 0 && c < DONE_C) begin
      e.busy = 1;
      s = (c - 1) / P;
      e.stg = STG_W'(s > LOG2N - 1 ? LOG2N - 1 : s);
    end
    e.done = (c == DONE_C);
    if (read_at(c, a, b, tw)) begin
      e.rv = 1; e.a = LOG2N'(a); e.b = LOG2N'(b); e.tw = (LOG2N-1)'(tw);
    end
    if (read_at(c - WR_LAT, a, b, tw)) begin
      e.we = 1; e.wa = LOG2N'(a); e.wb = LOG2N'(b);
    end
`ifdef FFT_AGU_BITREV_EN
    if (c > LOG2N * P && c <= LOG2N * P + NPTS) begin
      e.ov = 1; e.oa = LOG2N'(brev(c - LOG2N * P - 1));
    end
`endif
    return e;
  endfunction
  function automatic int get_sig(obs_t o, sig_e s);
    case (s)
      S_A: return int'(o.a);
      S_B: return int'(o.b);
      S_TW: return int'(o.tw);
      S_RV: return int'(o.rv);
      S_WE: return int'(o.we);
      S_WA: return int'(o.wa);
      S_WB: return int'(o.wb);
      S_BUSY: return int'(o.busy);
      S_DONE: return int'(o.done);
      S_STG: return int'(o.stg);
      S_OV: return int'(o.ov);
      default: return int'(o.oa);
    endcase
  endfunction
  function automatic obs_t observe();
    return '{busy, done, stage, rd_valid, rd_addr_a, rd_addr_b, tw_addr,
             wr_en, wr_addr_a, wr_addr_b, out_valid, out_addr};
  endfunction

  task automatic check(input bit ok, input string name, input int got, input int exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask

  // Model: cycles since the start edge; idle and the done cycle both accept a new start.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mc <= 0;
    else if (mc == 0 || mc == DONE_C) mc <= start ? 1 : 0;
    else mc <= mc + 1;
  end

  always @(posedge clk) begin
    obs_t act, exp;
    #1;
    if (chk_en) begin
      act = observe();
      exp = expect_at(mc);
      checks++;
      if (act !== exp) begin
        failures++;
        $display("FAIL model c=%0d got=%h expected=%h", mc, act, exp);
      end
      if (act.done) done_cnt++;
      if (rec_en && mc >= 1) trace[mc] = act;
    end
  end

  initial begin
    int rv_cnt, gaps, d0, k, len, ab;
`ifdef FFT_AGU_BITREV_EN
    vecs.push_back('{"rv_c1", 1, S_RV, 1});
    vecs.push_back('{"rv_c4", 4, S_RV, 1});
    vecs.push_back('{"rv_c5", 5, S_RV, 0});
    vecs.push_back('{"rv_c6", 6, S_RV, 1});
    vecs.push_back('{"rv_c10", 10, S_RV, 0});
    vecs.push_back('{"rv_c11", 11, S_RV, 1});
    vecs.push_back('{"rv_c14", 14, S_RV, 1});
    vecs.push_back('{"ov_c15", 15, S_OV, 0});
    vecs.push_back('{"ov_c16", 16, S_OV, 1});
    vecs.push_back('{"oa_c16", 16, S_OA, 0});
    vecs.push_back('{"oa_c17", 17, S_OA, 4});
    vecs.push_back('{"oa_c18", 18, S_OA, 2});
    vecs.push_back('{"oa_c19", 19, S_OA, 6});
    vecs.push_back('{"oa_c20", 20, S_OA, 1});
    vecs.push_back('{"oa_c23", 23, S_OA, 7});
    vecs.push_back('{"done_c23", 23, S_DONE, 0});
    vecs.push_back('{"done_c24", 24, S_DONE, 1});
    vecs.push_back('{"busy_c24", 24, S_BUSY, 0});
`else
    vecs.push_back('{"rv_c1", 1, S_RV, 1});
    vecs.push_back('{"busy_c1", 1, S_BUSY, 1});
    vecs.push_back('{"s0j3_a", 4, S_A, 6});
    vecs.push_back('{"s0j3_b", 4, S_B, 7});
    vecs.push_back('{"s0j3_tw", 4, S_TW, 0});
    vecs.push_back('{"s0j3_we", 8, S_WE, 1});
    vecs.push_back('{"s0j3_wa", 8, S_WA, 6});
    vecs.push_back('{"s0j3_wb", 8, S_WB, 7});
    vecs.push_back('{"gap_rv_c17", 17, S_RV, 0});
    vecs.push_back('{"last_wr_s0", 20, S_WE, 1});
    vecs.push_back('{"rv_c20", 20, S_RV, 0});
    vecs.push_back('{"rv_c21", 21, S_RV, 1});
    vecs.push_back('{"s1j1_a", 22, S_A, 4});
    vecs.push_back('{"s1j1_b", 22, S_B, 6});
    vecs.push_back('{"s1j5_tw", 26, S_TW, 0});
    vecs.push_back('{"s1j9_tw", 30, S_TW, 8});
    vecs.push_back('{"s4j1_a", 82, S_A, 1});
    vecs.push_back('{"s4j1_b", 82, S_B, 17});
    vecs.push_back('{"s4j1_tw", 82, S_TW, 1});
    vecs.push_back('{"s4_stage", 82, S_STG, 4});
    vecs.push_back('{"busy_c100", 100, S_BUSY, 1});
    vecs.push_back('{"done_c100", 100, S_DONE, 0});
    vecs.push_back('{"done_c101", 101, S_DONE, 1});
    vecs.push_back('{"busy_c101", 101, S_BUSY, 0});
`endif
    #2 rst_n = 0;
    chk_en = 1;
    repeat (3) tick();
    check(observe() == '0, "reset_state", int'(busy), 0);
    rst_n = 1;
    repeat (2) tick();
    // Directed transform recorded into the trace for the vector table.
    rec_en = 1;
    start = 1;
    tick();
    start = 0;
    repeat (DONE_C + 2) tick();
    rec_en = 0;
    foreach (vecs[i])
      check(get_sig(trace[vecs[i].cyc], vecs[i].sig) == vecs[i].val, vecs[i].name,
            get_sig(trace[vecs[i].cyc], vecs[i].sig), vecs[i].val);
    rv_cnt = 0;
    gaps = 0;
    for (int c = 1; c <= DONE_C; c++) begin
      rv_cnt += int'(trace[c].rv);
      if (c > 1 && trace[c].rv && !trace[c-1].rv) begin
        gaps++;
        check(trace[c-1].we && !trace[c].we, "hazard_gap", c, 0);
      end
    end
    check(rv_cnt == LOG2N * HALF, "rd_valid_count", rv_cnt, LOG2N * HALF);
    check(gaps == LOG2N - 1, "stage_gaps", gaps, LOG2N - 1);
    // Abort mid-transform, then restart.
    d0 = done_cnt;
    start = 1;
    tick();
    start = 0;
    repeat (ABORT_C - 1) tick();
    rst_n = 0;
    repeat (2) tick();
    check(observe() == '0, "abort_zero", int'(busy), 0);
    repeat (3) tick();
    rst_n = 1;
    repeat (3) tick();
    check(done_cnt == d0, "abort_no_done", done_cnt - d0, 0);
    start = 1;
    tick();
    start = 0;
    k = 1;
    while (!done && k < DONE_C + 20) begin
      tick();
      k++;
    end
    check(k == DONE_C, "restart_done_lat", k, DONE_C);
    repeat (3) tick();
    // Start held high: back-to-back transforms, one per IDLE entry.
    d0 = done_cnt;
    start = 1;
    repeat (2 * DONE_C) tick();
    start = 0;
    check(done_cnt - d0 == 2, "held_start_dones", done_cnt - d0, 2);
    repeat (DONE_C + 5) tick();
    check(busy == 0, "held_start_idle", int'(busy), 0);
    // Start pulses while busy must not restart.
    d0 = done_cnt;
    start = 1;
    tick();
    for (int c = 1; c < DONE_C + 5; c++) begin
      start = (c == DONE_C / 4 || c == DONE_C / 2);
      tick();
    end
    start = 0;
    check(done_cnt - d0 == 1, "pulse_busy_dones", done_cnt - d0, 1);
    check(busy == 0, "pulse_busy_idle", int'(busy), 0);
    // Random start activity and random aborts against the model.
    for (int it = 0; it < 12; it++) begin
      len = $urandom_range(DONE_C / 2, 2 * DONE_C);
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, len - 1) : -1;
      for (int c = 0; c < len; c++) begin
        start = ($urandom_range(0, 3) == 0);
        tick();
        if (c == ab) begin
          rst_n = 0;
          repeat ($urandom_range(1, 3)) tick();
          rst_n = 1;
        end
      end
    end
    start = 0;
    repeat (DONE_C + 5) tick();
    check(busy == 0, "final_idle", int'(busy), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fft_addr_gen_param.md
Name: fft_addr_gen_param

Overview:
- Parametrised address generation unit for an in-place, constant-geometry radix-2 FFT of N = 2**LOG2N points.
- Per stage, it sequences read addresses for operands A and B plus a twiddle ROM address.
- It delays those addresses by the butterfly pipeline latency to produce write-back addresses.
- It inserts drain gaps at stage boundaries to remove RAW hazards, and signals completion.
- Sits between the FFT controller (start/done) and the dual data memories plus twiddle ROM.

Parameters:
- LOG2N, 5, log2 of FFT length; legal range 2..12.
- WR_LAT, 4, cycles from a read address to its butterfly result being written; legal range 1..15.
- STG_W, derived = $clog2(LOG2N), width of the stage index (localparam, not overridable).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  level; sampled only in IDLE; begins a transform.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the transform is complete.
- stage  out  STG_W  current stage s, 0..LOG2N-1.
- rd_valid  out  1  rd_addr_a/rd_addr_b/tw_addr valid this cycle.
- rd_addr_a  out  LOG2N  operand A read address.
- rd_addr_b  out  LOG2N  operand B read address.
- tw_addr  out  LOG2N-1  twiddle ROM address.
- wr_en  out  1  write strobe for both memories.
- wr_addr_a  out  LOG2N  write address A.
- wr_addr_b  out  LOG2N  write address B.
- out_valid  out  1  unload strobe (FFT_AGU_BITREV_EN only; else tied 0).
- out_addr  out  LOG2N  bit-reversed unload address (else tied 0).

Behaviour:
- Reset: asynchronous. All outputs are 0, FSM in IDLE, write delay line cleared. rst_n low mid-transform aborts immediately with no done pulse.
- FSM states: IDLE, RUN, DRAIN, UNLOAD (macro only), then back to IDLE.
- IDLE to RUN on start=1. Start is ignored while busy.
- RUN:
  - Butterfly counter j runs 0..N/2-1, one per cycle, with rd_valid=1.
  - rd_addr_a = rotl(2j, s) over LOG2N bits; rd_addr_b = rotl(2j+1, s).
  - tw_addr = j AND mask_s, where mask_s has the top s bits of LOG2N-1 set (stage 0: all zero; stage LOG2N-1: all ones).
  - At j=N/2-1, go to DRAIN.
- DRAIN:
  - rd_valid=0 for exactly WR_LAT cycles, so the next stage's first read is the cycle after the previous stage's last write.
  - Then either s++ and return to RUN with j=0, or after the last stage go to IDLE (or UNLOAD when the macro is defined).
- Write path: {rd_valid, rd_addr_a, rd_addr_b} delayed exactly WR_LAT cycles becomes {wr_en, wr_addr_a, wr_addr_b}.
- Timing, with start accepted at cycle 0 and P = N/2 + WR_LAT:
  - Stage s reads occupy cycles 1+s*P .. s*P+N/2.
  - done pulses at cycle 1+LOG2N*P, together with busy falling and the last-stage IDLE transition.
  - busy is high from cycle 1.
- Counter wrap: j rolls to 0 only at a stage boundary. stage never exceeds LOG2N-1.
- start held high across done begins a new transform the cycle after IDLE is re-entered; there are no back-to-back overlapping transforms.

Optional Feature:
- FFT_AGU_BITREV_EN defined:
  - After the final DRAIN, the FSM enters UNLOAD for N cycles.
  - out_valid=1 and out_addr = bitreverse(k) for k=0..N-1.
  - done is delayed to cycle 1+LOG2N*P+N.
- Not defined: no UNLOAD state, out_valid and out_addr are constant 0, and done timing is as above.

Decomposition:
- Package fft_agu_pkg:
  - FSM state enum.
  - Functions rotl_n(value, amount, width) and bitrev_n(value, width).
  - Twiddle mask generation function.
- Sub-module fft_agu_wr_delay: parametrised (width, WR_LAT) shift-register delay line with async active-low clear, used for the write path.

Test Plan:
- Defaults, start pulse at cycle 0: stage 0, j=3 gives rd_addr_a=6, rd_addr_b=7, tw_addr=0. The same addresses appear on wr_* with wr_en at cycle 8.
- Stage 1: j=1 gives a=4, b=6; j=5 gives tw=0; j=9 gives tw=8. Stage 4: j=1 gives a=1, b=17, tw=1.
- Full run, defaults: exactly 80 rd_valid cycles. There is a 4-cycle gap between stages, with no read of stage s+1 before the last write of stage s. done at cycle 101 and busy falls at cycle 101.
- Reset abort: drop rst_n at cycle 40, release at cycle 45. All outputs are 0 with no done pulse, and a new start is then accepted normally.
- start held high continuously and also pulsed mid-run: exactly one transform per IDLE entry, with no restart while busy.
- FFT_AGU_BITREV_EN, LOG2N=3, WR_LAT=1 (P=5):
  - Stage reads at cycles 1..4, 6..9, 11..14.
  - out_addr sequence 0,4,2,6,1,5,3,7 on cycles 16..23.
  - done at cycle 24.
